// File: rtl/bk_ap_ctrl_initiator.sv
// ap_ctrl-style initiator: software start edge -> one start pulse, then wait for done with timeout/abort.
// Optional macro BK_AP_CTRL_IRQ_EN enables the registered irq_o level output.
module bk_ap_ctrl_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ctrl_reg_i,
  output logic        ap_start_pedge_o,
  input  logic        ap_done_i,
  output logic [31:0] status_reg_o,
  output logic [31:0] latency_o,
  output logic        irq_o
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned RUN_W = 16;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_q;
  logic               start_q;
  logic               pedge_q;
  logic               idle_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   lat_q;
  logic [RUN_W-1:0]   run_q;
  logic               done_s_q;
  logic               tmo_s_q;
  logic               abort_s_q;

  logic start_c, auto_c, clr_c, abort_c;
  logic start_edge_c, in_wait_c;
  logic done_evt_c, abort_evt_c, tmo_evt_c;
  logic done_s_d, tmo_s_d, abort_s_d;
  logic unused_ctrl_c;

  assign start_c       = ctrl_reg_i[0];
  assign auto_c        = ctrl_reg_i[1];
  assign clr_c         = ctrl_reg_i[2];
  assign abort_c       = ctrl_reg_i[3];
  assign unused_ctrl_c = ^ctrl_reg_i[31:4];

  // WAIT exits in priority order: done, abort, timeout
  always_comb begin
    start_edge_c = start_c & ~start_q;
    in_wait_c    = (state_q == WAIT);
    done_evt_c   = in_wait_c & ap_done_i;
    abort_evt_c  = in_wait_c & ~ap_done_i & abort_c;
    tmo_evt_c    = in_wait_c & ~ap_done_i & ~abort_c &
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // a set event overrides a same-cycle clear
    done_s_d     = (state_q == DONE) | (done_s_q  & ~clr_c);
    tmo_s_d      = tmo_evt_c         | (tmo_s_q   & ~clr_c);
    abort_s_d    = abort_evt_c       | (abort_s_q & ~clr_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      pedge_q <= 1'b0;
      idle_q  <= 1'b1;
      cnt_q   <= '0;
      lat_q   <= '0;
      run_q   <= '0;
    end else begin
      start_q <= start_c;
      pedge_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge_c) begin
            state_q <= START;
            pedge_q <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (done_evt_c) begin
            lat_q   <= cnt_q + CNT_W'(1);
            state_q <= DONE;
          end else if (abort_evt_c || tmo_evt_c) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          run_q <= run_q + RUN_W'(1);
          if (auto_c && !abort_c) begin
            state_q <= START;
            pedge_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_s_q  <= 1'b0;
      tmo_s_q   <= 1'b0;
      abort_s_q <= 1'b0;
    end else begin
      done_s_q  <= done_s_d;
      tmo_s_q   <= tmo_s_d;
      abort_s_q <= abort_s_d;
    end
  end

`ifdef BK_AP_CTRL_IRQ_EN
  logic irq_q;

  // follows the next sticky values so irq tracks the stickies without lag
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= done_s_d | tmo_s_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign ap_start_pedge_o = pedge_q;
  assign latency_o        = lat_q;
  assign status_reg_o     = {run_q, 11'b0, abort_s_q, tmo_s_q, done_s_q, ~idle_q, idle_q};

endmodule

// File: tb/tb_bk_ap_ctrl_initiator.sv
// Directed bench for bk_ap_ctrl_initiator; outputs sampled and inputs driven on the falling edge.
module tb_bk_ap_ctrl_initiator;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_reg_i;
  logic        ap_start_pedge_o;
  logic        ap_done_i;
  logic [31:0] status_reg_o;
  logic [31:0] latency_o;
  logic        irq_o;

  int n_cmp;
  int n_err;

`ifdef BK_AP_CTRL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  bk_ap_ctrl_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctrl_reg_i       (ctrl_reg_i),
    .ap_start_pedge_o (ap_start_pedge_o),
    .ap_done_i        (ap_done_i),
    .status_reg_o     (status_reg_o),
    .latency_o        (latency_o),
    .irq_o            (irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bounded wait for the start pulse; leaves us on the falling edge of the pulse cycle
  task automatic wait_pulse(input string tag);
    int i;
    i = 0;
    while (ap_start_pedge_o !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(ap_start_pedge_o), 32'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    ctrl_reg_i = 32'h0;
    ap_done_i  = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_status",  status_reg_o, 32'h0000_0001);
    chk("rst_latency", latency_o, 32'h0);
    chk("rst_pedge",   32'(ap_start_pedge_o), 32'h0);
    chk("rst_irq",     32'(irq_o), 32'h0);

    // normal run, done 5 cycles after the pulse, start held high afterwards
    ctrl_reg_i = 32'h1;
    wait_pulse("t1_pulse");
    step(1);
    chk("t1_one_pulse", 32'(ap_start_pedge_o), 32'h0);
    step(4);
    ap_done_i = 1'b1;
    step(1);
    ap_done_i = 1'b0;
    chk("t1_done_state", status_reg_o, 32'h0000_0002);
    step(1);
    chk("t1_status",  status_reg_o, 32'h0001_0005);
    chk("t1_latency", latency_o, 32'd5);
    chk("t1_irq",     32'(irq_o), 32'(IRQ_EN));
    step(3);
    chk("t1_no_retrig", 32'(ap_start_pedge_o), 32'h0);
    chk("t1_still_idle", status_reg_o, 32'h0001_0005);

    ctrl_reg_i = 32'h4;
    step(1);
    chk("t1_clear", status_reg_o, 32'h0001_0001);
    chk("t1_clear_lat", latency_o, 32'd5);

    // timeout, with a start re-edge while busy and a late done
    ctrl_reg_i = 32'h1;
    wait_pulse("t2_pulse");
    step(3);
    ctrl_reg_i = 32'h0;
    step(1);
    ctrl_reg_i = 32'h1;
    step(12);
    chk("t2_busy_p16", status_reg_o, 32'h0001_0002);
    step(1);
    chk("t2_timeout", status_reg_o, 32'h0001_0009);
    chk("t2_irq",     32'(irq_o), 32'(IRQ_EN));
    step(3);
    ap_done_i = 1'b1;
    step(1);
    ap_done_i = 1'b0;
    chk("t2_late_done", status_reg_o, 32'h0001_0009);
    chk("t2_no_busy_edge", 32'(ap_start_pedge_o), 32'h0);
    chk("t2_latency", latency_o, 32'd5);

    ctrl_reg_i = 32'h4;
    step(1);
    chk("t2_clear", status_reg_o, 32'h0001_0001);
    chk("t2_irq_clr", 32'(irq_o), 32'h0);

    // auto-restart with done 3 cycles after each pulse; stop on third run
    ctrl_reg_i = 32'h3;
    wait_pulse("t3_pulse");
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ctrl_reg_i = 32'h1;
      step(3);
      ap_done_i = 1'b1;
      step(1);
      ap_done_i = 1'b0;
      step(1);
      chk($sformatf("t3_pedge%0d", i), 32'(ap_start_pedge_o), (i < 2) ? 32'd1 : 32'd0);
      chk($sformatf("t3_run%0d", i), 32'(status_reg_o[31:16]), 32'(2 + i));
    end
    chk("t3_status",  status_reg_o, 32'h0004_0005);
    chk("t3_latency", latency_o, 32'd3);

    // abort at pulse+2
    ctrl_reg_i = 32'h4;
    step(1);
    ctrl_reg_i = 32'h1;
    wait_pulse("t4_pulse");
    step(2);
    ctrl_reg_i = 32'h9;
    step(1);
    ctrl_reg_i = 32'h0;
    chk("t4_abort", status_reg_o, 32'h0004_0011);
    chk("t4_irq",   32'(irq_o), 32'h0);

    // done in the same cycle as abort: done wins
    ctrl_reg_i = 32'h4;
    step(1);
    ctrl_reg_i = 32'h1;
    wait_pulse("t5_pulse");
    step(2);
    ctrl_reg_i = 32'h9;
    ap_done_i  = 1'b1;
    step(1);
    ctrl_reg_i = 32'h0;
    ap_done_i  = 1'b0;
    step(1);
    chk("t5_status",  status_reg_o, 32'h0005_0005);
    chk("t5_latency", latency_o, 32'd2);

    // clear_status held through a done: the set wins
    ctrl_reg_i = 32'h4;
    step(1);
    ctrl_reg_i = 32'h5;
    wait_pulse("t6_pulse");
    step(1);
    ap_done_i = 1'b1;
    step(1);
    ap_done_i = 1'b0;
    chk("t6_done_state", status_reg_o, 32'h0005_0002);
    chk("t6_irq_cleared", 32'(irq_o), 32'h0);
    step(1);
    chk("t6_status",  status_reg_o, 32'h0006_0005);
    chk("t6_irq",     32'(irq_o), 32'(IRQ_EN));
    chk("t6_latency", latency_o, 32'd1);
    ctrl_reg_i = 32'h0;

    // reset at pulse+2, then a normal run
    step(1);
    ctrl_reg_i = 32'h1;
    wait_pulse("t7_pulse");
    step(2);
    rst_n      = 1'b0;
    ctrl_reg_i = 32'h0;
    step(1);
    rst_n = 1'b1;
    chk("t7_rst_status",  status_reg_o, 32'h0000_0001);
    chk("t7_rst_latency", latency_o, 32'h0);
    chk("t7_rst_irq",     32'(irq_o), 32'h0);
    step(1);
    ctrl_reg_i = 32'h1;
    wait_pulse("t7_pulse2");
    step(4);
    ap_done_i = 1'b1;
    step(1);
    ap_done_i = 1'b0;
    step(1);
    chk("t7_status",  status_reg_o, 32'h0001_0005);
    chk("t7_latency", latency_o, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
